// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter generator with boot/run/halt control
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter int INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h00000000),
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h00000100)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              trap_flag,
  input  logic              halt_req,
  input  logic              inst_mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_mem_en,
  output logic              misalign_fault,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Increment and the alignment mask share the power-of-two instruction size;
  // a size of 1 gives an all-zero mask, so nothing is ever misaligned.
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              fault_n;
  logic              misaligned;

  assign misaligned = |(branch_target & ALIGN_MASK);

  // State, pc and all outputs are flops; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_VEC;
      inst_mem_en    <= 1'b0;
      misalign_fault <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      inst_mem_en    <= (state_n == RUN);
      misalign_fault <= fault_n;
      halted         <= (state_n == HALT);
    end
  end

  // Next state and next pc: redirects beat halt, halt beats hold/increment.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    fault_n = 1'b0;
    case (state)
      BOOT: begin
        // First fetch is the reset vector itself, so pc is not advanced here.
        state_n = RUN;
      end
      RUN: begin
        if (trap_flag) begin
          pc_n = TRAP_VEC;
        end else if (branch_flag) begin
          if (misaligned) begin
            pc_n    = TRAP_VEC;
            fault_n = 1'b1;
          end else begin
            pc_n = branch_target;
          end
        end else if (halt_req) begin
          state_n = HALT;
        end else if (!stall && inst_mem_ready) begin
          pc_n = pc + PC_INC;
        end
      end
      HALT: begin
        if (trap_flag) begin
          pc_n    = TRAP_VEC;
          state_n = RUN;
        end else if (!halt_req) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = BOOT;
        pc_n    = RESET_VEC;
      end
    endcase
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, meaning the PC and target width in bits.
REQ-002 SHALL provide parameter INST_BYTES, default 4, meaning the PC increment per fetch; it is a power of two, 1 to 8.
REQ-003 SHALL provide parameter RESET_VEC, default 32'h00000000, meaning the first fetch address after reset.
REQ-004 SHALL provide parameter TRAP_VEC, default 32'h00000100, meaning the fetch address after a trap or a misaligned redirect.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port stall, input, 1 bit: when 1, downstream cannot accept; hold pc.
REQ-008 SHALL have port branch_flag, input, 1 bit: redirect request for this cycle.
REQ-009 SHALL have port branch_target, input, ADDR_W bits: redirect address.
REQ-010 SHALL have port trap_flag, input, 1 bit: exception redirect to TRAP_VEC.
REQ-011 SHALL have port halt_req, input, 1 bit: level request to stop fetching.
REQ-012 SHALL have port inst_mem_ready, input, 1 bit: instruction memory accepted the current pc.
REQ-013 SHALL have port pc, output, ADDR_W bits: the current fetch address, registered.
REQ-014 SHALL have port inst_mem_en, output, 1 bit: chip enable to instruction memory, registered.
REQ-015 SHALL have port misalign_fault, output, 1 bit: one-cycle pulse for a misaligned branch_target.
REQ-016 SHALL have port halted, output, 1 bit: 1 while in the HALT state.

Function
REQ-017 SHALL implement three states: BOOT, RUN and HALT.
REQ-018 SHALL enter BOOT while rst=1; in BOOT, inst_mem_en=0 and pc=RESET_VEC.
REQ-019 SHALL move BOOT->RUN on the first edge with rst=0; in that cycle, inst_mem_en becomes 1 and pc stays RESET_VEC, so the first fetch is RESET_VEC.
REQ-020 SHALL, in RUN, set inst_mem_en=1 and update pc once per edge with this priority, highest first:
- trap_flag: pc=TRAP_VEC.
- branch_flag with aligned target: pc=branch_target.
- branch_flag with misaligned target: pc=TRAP_VEC.
- stall=1 or inst_mem_ready=0: pc held.
- otherwise: pc=pc+INST_BYTES.
REQ-021 SHALL treat branch_target as misaligned when any of its low log2(INST_BYTES) bits is nonzero; for INST_BYTES=1 it is never misaligned.
REQ-022 SHALL, on a misaligned redirect, assert misalign_fault for exactly the next cycle; in every other case misalign_fault=0.
REQ-023 SHALL apply trap_flag and branch_flag even when stall=1 or inst_mem_ready=0 (a redirect overrides a hold).
REQ-024 SHALL let trap_flag win over a simultaneous branch_flag; misalign_fault is not raised in that cycle.
REQ-025 SHALL compute the increment modulo 2^ADDR_W, so the maximum aligned address wraps to 0 with no flag.
REQ-026 SHALL move RUN->HALT on an edge with halt_req=1 when no trap or branch is present.
REQ-027 SHALL, on entry to HALT, hold pc at its current value and set inst_mem_en=0 and halted=1.
REQ-028 SHALL, if halt_req=1 coincides with trap_flag or branch_flag, perform the redirect first and stay in RUN; the halt is taken on a later edge if halt_req is still 1.
REQ-029 SHALL, in HALT, ignore stall, inst_mem_ready and branch_flag.
REQ-030 SHALL, in HALT, respond to trap_flag by setting pc=TRAP_VEC and moving to RUN.
REQ-031 SHALL move HALT->RUN when halt_req=0; on that edge inst_mem_en=1, halted=0, and pc is unchanged, so the fetch resumes at the held address.
REQ-032 SHALL have a one-edge latency from any input to pc, inst_mem_en, misalign_fault and halted.

Reset
REQ-033 SHALL, on any edge with rst=1 in any state (mid-fetch, mid-stall or HALT), set state=BOOT, pc=RESET_VEC, inst_mem_en=0, misalign_fault=0 and halted=0.
REQ-034 SHALL let rst override all other inputs.

Verification
REQ-035 SHALL cover reset release: defaults, rst 1 for 3 cycles then 0, ready=1 -> inst_mem_en 0,0,0,1; pc 0,0,0,0,4,8,C.
REQ-036 SHALL cover stall and not-ready: pc=0x10, stall=1 for 2 cycles, then ready=0 for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14.
REQ-037 SHALL cover redirects:
- branch_flag with target 0x40 while stall=1 -> pc=0x40 next edge.
- target 0x42 -> pc=0x100 and misalign_fault=1 for one cycle.
REQ-038 SHALL cover a simultaneous trap and branch: trap_flag and branch_flag (target 0x40) together -> pc=0x100, misalign_fault=0.
REQ-039 SHALL cover halt and resume: halt_req=1 at pc=0x20 -> halted=1, inst_mem_en=0, pc=0x20; halt_req=0 -> halted=0, inst_mem_en=1, then pc=0x24.
REQ-040 SHALL cover wrap and reset in HALT:
- ADDR_W=8, INST_BYTES=4, pc=0xFC -> pc=0x00.
- rst=1 while halted -> pc=RESET_VEC, halted=0, inst_mem_en=0.
